// File: rtl/demux_width_chan_reg.sv
// Registered 1-to-CHANNELS demultiplexer with a one-entry register and valid/ready per channel.
// Latency 1 cycle; a full channel can load and drain in the same cycle; out-of-range selects are dropped.
module demux_width_chan_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [3:0]                in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_bus,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err_sel,
  output logic [7:0]                drop_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              r_state [CHANNELS];
  logic [WIDTH-1:0]    r_data  [CHANNELS];
  logic                r_err;
  logic [7:0]          r_drops;

  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_chan_rdy;
  logic                w_in_range;
  logic                w_accept;
  logic                w_drop;

  // One-hot decode avoids a constant compare when CHANNELS covers all 16 selects.
  genvar ch;
  generate
    for (ch = 0; ch < CHANNELS; ch++) begin : g_chan
      logic w_load;
      logic w_drain;

      assign w_hit[ch]      = (in_sel == 4'(ch));
      assign w_chan_rdy[ch] = (r_state[ch] == EMPTY) || out_ready[ch];
      assign w_load         = w_accept && w_hit[ch];
      assign w_drain        = (r_state[ch] == FULL) && out_ready[ch];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state[ch] <= EMPTY;
          r_data[ch]  <= '0;
        end else begin
          case (r_state[ch])
            EMPTY: if (w_load) begin
              r_state[ch] <= FULL;
              r_data[ch]  <= in_data;
            end
            FULL: if (w_load) begin
              r_data[ch]  <= in_data;
            end else if (w_drain) begin
              r_state[ch] <= EMPTY;
            end
            default: r_state[ch] <= EMPTY;
          endcase
        end
      end

      assign out_bus[ch*WIDTH +: WIDTH] = r_data[ch];
      assign out_valid[ch]              = (r_state[ch] == FULL);
    end
  endgenerate

  assign w_in_range = |w_hit;
  assign in_ready   = !w_in_range || |(w_hit & w_chan_rdy);
  assign w_accept   = in_valid && in_ready;
  assign w_drop     = in_valid && !w_in_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err   <= 1'b0;
      r_drops <= 8'h00;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_drops != 8'hFF)) begin
        r_drops <= r_drops + 8'h01;
      end
    end
  end

  assign err_sel    = r_err;
  assign drop_count = r_drops;

endmodule
